base_cntr_sweep: RTL

//  Read initiator for the SRAM-backed counter bank: on a start request it walks counter

---
 rtl/base_cntr_sweep.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/base_cntr_sweep.sv
// base_cntr_sweep
//   Read initiator for the SRAM-backed counter bank. A start request begins a
//   sweep. The sweep issues one read per counter address 0..n-1, and at most
//   max_out reads are in flight at any time. Read data comes back in order.
//   Each word is tagged with its address and streamed out through a single
//   output register stage.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_start_v / i_start_r      sweep request handshake (ready only while idle)
//   o_rd_v / o_rd_r / o_rd_a   read request to the counter bank
//   i_rd_v / i_rd_r / i_rd_d   read data from the counter bank
//   o_v / o_r / o_a / o_d      tagged result beat
//   o_last                     result beat carries address n-1
//   o_busy                     sweep in progress
//   o_done                     one-cycle pulse after the last beat is taken
module base_cntr_sweep #(
  parameter int width      = 32,
  parameter int n          = 16,
  parameter int addr_width = $clog2(n),
  parameter int max_out    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start_v,
  output logic                  i_start_r,
  output logic                  o_rd_v,
  input  logic                  o_rd_r,
  output logic [addr_width-1:0] o_rd_a,
  input  logic                  i_rd_v,
  output logic                  i_rd_r,
  input  logic [width-1:0]      i_rd_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [addr_width-1:0] o_a,
  output logic [width-1:0]      o_d,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int cnt_width = $clog2(max_out + 1);
  localparam logic [cnt_width-1:0]  cnt_max   = cnt_width'(max_out);
  localparam logic [addr_width-1:0] addr_last = addr_width'(n - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] issue_addr;
  logic [addr_width-1:0] ret_addr;
  logic [cnt_width-1:0]  out_cnt;
  logic                  req_fire;
  logic                  load;
  logic                  out_fire;

  assign o_rd_a   = issue_addr;
  assign o_busy   = (state != IDLE);
  assign req_fire = o_rd_v & o_rd_r;
  // Data accepted while idle is stale (left over from an aborted sweep) and is dropped.
  assign load     = i_rd_v & i_rd_r & (state != IDLE);
  assign out_fire = o_v & o_r;

  // Next-state, handshake readies and request valid.
  always_comb begin
    state_nxt = state;
    i_start_r = 1'b0;
    o_rd_v    = 1'b0;
    i_rd_r    = ~o_v | o_r;
    case (state)
      IDLE: begin
        i_start_r = 1'b1;
        i_rd_r    = 1'b1;
        if (i_start_v) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        // Credit check uses the registered count only; a return in the
        // same cycle does not free a slot until the next cycle.
        o_rd_v = (out_cnt < cnt_max);
        if (o_rd_v && o_rd_r && (issue_addr == addr_last)) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        if (out_fire && o_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, issue/return address counters and in-flight credit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      issue_addr <= '0;
      ret_addr   <= '0;
      out_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && i_start_v) begin
        issue_addr <= '0;
        ret_addr   <= '0;
      end else begin
        if (req_fire) begin
          issue_addr <= issue_addr + addr_width'(1);
        end
        if (load) begin
          ret_addr <= ret_addr + addr_width'(1);
        end
      end
      case ({req_fire, load})
        2'b10:   out_cnt <= out_cnt + cnt_width'(1);
        2'b01:   out_cnt <= out_cnt - cnt_width'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Output register stage and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_v    <= 1'b0;
      o_a    <= '0;
      o_d    <= '0;
      o_last <= 1'b0;
      o_done <= 1'b0;
    end else begin
      if (load) begin
        o_v    <= 1'b1;
        o_d    <= i_rd_d;
        o_a    <= ret_addr;
        o_last <= (ret_addr == addr_last);
      end else if (out_fire) begin
        o_v <= 1'b0;
      end
      o_done <= (state == DRAIN) && out_fire && o_last;
    end
  end

endmodule
